// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter : round-robin front end sharing one ALU between two requesters
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [OPW-1:0]   r0_op,
  input  logic             r0_setflags,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [OPW-1:0]   r1_op,
  input  logic             r1_setflags,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v,

  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_flags,
  input  logic             res_ready,

  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             sf_q, sf_d;
  logic             id_q, id_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic [3:0]       flags_q, flags_d;
  logic             w_pick1;

  // r1 wins when it is alone, or on a tie when r0 was granted last.
  assign w_pick1 = r1_valid & (~r0_valid | ~last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sf_d        = sf_q;
    id_d        = id_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    flags_d     = flags_q;
    r0_ready    = 1'b0;
    r1_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!reset) begin
          r0_ready = r0_valid & ~w_pick1;
          r1_ready = w_pick1;
        end
        if (r0_ready || r1_ready) begin
          a_d     = w_pick1 ? r1_a        : r0_a;
          b_d     = w_pick1 ? r1_b        : r0_b;
          op_d    = w_pick1 ? r1_op       : r0_op;
          sf_d    = w_pick1 ? r1_setflags : r0_setflags;
          id_d    = w_pick1;
          last_d  = w_pick1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_out;
        res_flags_d = {alu_z, alu_n, alu_c, alu_v};
        res_id_d    = id_q;
        if (sf_q) begin
          flags_d = {alu_z, alu_n, alu_c, alu_v};
        end
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      sf_q        <= 1'b0;
      id_q        <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      sf_q        <= sf_d;
      id_q        <= id_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      flags_q     <= flags_d;
    end
  end

  // The ALU only ever sees registered operands, so it is isolated from request-side glitches.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign res_valid = (state_q == DONE);
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign flags     = flags_q;

endmodule

`default_nettype wire
